// File: rtl/zion_sign_mag_to_twos_pipe.sv
// -----------------------------------------------------------------------------
// zion_sign_mag_to_twos_pipe
//
// Streaming sign-magnitude to two's-complement converter, two pipeline stages,
// valid/ready handshake on both sides, full throughput, lossless backpressure.
//
// Stage 1 registers the conditionally inverted magnitude plus the carry-in
// (the sign). Stage 2 registers the final add. oDat/oVld come straight from
// the stage-2 registers.
//
// Parameters:
//   WIDTH_IN   input word width (MSB = sign, rest = magnitude), >= 2
//   WIDTH_OUT  output two's-complement width, >= 2
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   iVld  input word valid
//   iRdy  converter can accept a word this cycle (combinational from oRdy)
//   iDat  sign-magnitude input word
//   oVld  output word valid
//   oRdy  downstream accepts the output word
//   oDat  two's-complement result, wrapped modulo 2^WIDTH_OUT
//   oOvf  (only with ZION_SM2TC_OVF_FLAG_EN) input value not representable
//         in WIDTH_OUT bits; aligned with oDat, qualified by oVld
//
// Build option:
//   ZION_SM2TC_OVF_FLAG_EN  adds the oOvf port and its pipelined flag logic.
// -----------------------------------------------------------------------------
module zion_sign_mag_to_twos_pipe #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iVld,
  output logic                 iRdy,
  input  logic [WIDTH_IN-1:0]  iDat,
  output logic                 oVld,
  input  logic                 oRdy,
  output logic [WIDTH_OUT-1:0] oDat
`ifdef ZION_SM2TC_OVF_FLAG_EN
  ,
  output logic                 oOvf
`endif
);

  localparam int MAG_W = WIDTH_IN - 1;
  // Comparison width wide enough for both the full magnitude and 2^(WIDTH_OUT-1).
  localparam int CMP_W = ((MAG_W > WIDTH_OUT) ? MAG_W : WIDTH_OUT) + 1;

  // ---------------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------------
  logic                 sign_w;
  logic [CMP_W-1:0]     mag_ext_w;
  logic [WIDTH_OUT-1:0] mag_w;

  assign sign_w    = iDat[WIDTH_IN-1];
  assign mag_ext_w = {{(CMP_W-MAG_W){1'b0}}, iDat[MAG_W-1:0]};
  // Zero-extends or truncates the magnitude to the output width.
  assign mag_w     = mag_ext_w[WIDTH_OUT-1:0];

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic                 s1_vld_q,  s1_vld_d;
  logic                 s1_sign_q, s1_sign_d;   // also the carry-in of the S2 add
  logic [WIDTH_OUT-1:0] s1_inv_q,  s1_inv_d;
  logic                 s2_vld_q,  s2_vld_d;
  logic [WIDTH_OUT-1:0] s2_dat_q,  s2_dat_d;

  logic s1_adv;
  logic s2_adv;

  // A stage may advance when it is empty or its successor is advancing.
  assign s2_adv = ~s2_vld_q | oRdy;
  assign s1_adv = ~s1_vld_q | s2_adv;
  assign iRdy   = s1_adv;

  assign oVld = s2_vld_q;
  assign oDat = s2_dat_q;

`ifdef ZION_SM2TC_OVF_FLAG_EN
  localparam logic [CMP_W-1:0] ONE_C   = {{(CMP_W-1){1'b0}}, 1'b1};
  localparam logic [CMP_W-1:0] NEG_LIM = ONE_C << (WIDTH_OUT-1);
  localparam logic [CMP_W-1:0] POS_LIM = NEG_LIM - ONE_C;

  logic ovf_w;
  logic s1_ovf_q, s1_ovf_d;
  logic s2_ovf_q, s2_ovf_d;

  // Evaluated on the untruncated magnitude; negative side allows one more.
  assign ovf_w = sign_w ? (mag_ext_w > NEG_LIM) : (mag_ext_w > POS_LIM);
  assign oOvf  = s2_ovf_q;
`else
  // Upper magnitude bits only feed the overflow flag, absent in this build.
  logic unused_mag_w;
  assign unused_mag_w = ^mag_ext_w;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave one
    // unassigned and infer a latch.
    s1_vld_d  = s1_vld_q;
    s1_sign_d = s1_sign_q;
    s1_inv_d  = s1_inv_q;
    s2_vld_d  = s2_vld_q;
    s2_dat_d  = s2_dat_q;
`ifdef ZION_SM2TC_OVF_FLAG_EN
    s1_ovf_d  = s1_ovf_q;
    s2_ovf_d  = s2_ovf_q;
`endif

    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_dat_d = s1_inv_q + {{(WIDTH_OUT-1){1'b0}}, s1_sign_q};
`ifdef ZION_SM2TC_OVF_FLAG_EN
        s2_ovf_d = s1_ovf_q;
`endif
      end
    end

    if (s1_adv) begin
      s1_vld_d = iVld;
      // iDat is only captured on an actual transfer.
      if (iVld) begin
        s1_sign_d = sign_w;
        s1_inv_d  = sign_w ? ~mag_w : mag_w;
`ifdef ZION_SM2TC_OVF_FLAG_EN
        s1_ovf_d  = ovf_w;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are reset too, so oDat reads 0 right after reset
      // rather than stale pre-reset contents.
      s1_vld_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_inv_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_dat_q  <= '0;
`ifdef ZION_SM2TC_OVF_FLAG_EN
      s1_ovf_q  <= 1'b0;
      s2_ovf_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      s1_vld_q  <= s1_vld_d;
      s1_sign_q <= s1_sign_d;
      s1_inv_q  <= s1_inv_d;
      s2_vld_q  <= s2_vld_d;
      s2_dat_q  <= s2_dat_d;
`ifdef ZION_SM2TC_OVF_FLAG_EN
      s1_ovf_q  <= s1_ovf_d;
      s2_ovf_q  <= s2_ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_zion_sign_mag_to_twos_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for zion_sign_mag_to_twos_pipe.
// Three instances: 8->8 (main), 8->4 (narrow), 4->8 (wide).
// Each cycle: inputs driven 1 ns after the rising edge, outputs sampled 2 ns
// after it, so the transfer decision is taken on settled values.
// -----------------------------------------------------------------------------
module tb_zion_sign_mag_to_twos_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       a_ivld, a_irdy, a_ovld, a_ordy;
  logic [7:0] a_idat, a_odat;

  logic       n_ivld, n_irdy, n_ovld, n_ordy;
  logic [7:0] n_idat;
  logic [3:0] n_odat;

  logic       w_ivld, w_irdy, w_ovld, w_ordy;
  logic [3:0] w_idat;
  logic [7:0] w_odat;

`ifdef ZION_SM2TC_OVF_FLAG_EN
  logic a_ovf, n_ovf, w_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  zion_sign_mag_to_twos_pipe #(.WIDTH_IN(8), .WIDTH_OUT(8)) u_main (
    .clk(clk), .rst(rst),
    .iVld(a_ivld), .iRdy(a_irdy), .iDat(a_idat),
    .oVld(a_ovld), .oRdy(a_ordy), .oDat(a_odat)
`ifdef ZION_SM2TC_OVF_FLAG_EN
    , .oOvf(a_ovf)
`endif
  );

  zion_sign_mag_to_twos_pipe #(.WIDTH_IN(8), .WIDTH_OUT(4)) u_narrow (
    .clk(clk), .rst(rst),
    .iVld(n_ivld), .iRdy(n_irdy), .iDat(n_idat),
    .oVld(n_ovld), .oRdy(n_ordy), .oDat(n_odat)
`ifdef ZION_SM2TC_OVF_FLAG_EN
    , .oOvf(n_ovf)
`endif
  );

  zion_sign_mag_to_twos_pipe #(.WIDTH_IN(4), .WIDTH_OUT(8)) u_wide (
    .clk(clk), .rst(rst),
    .iVld(w_ivld), .iRdy(w_irdy), .iDat(w_idat),
    .oVld(w_ovld), .oRdy(w_ordy), .oDat(w_odat)
`ifdef ZION_SM2TC_OVF_FLAG_EN
    , .oOvf(w_ovf)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Reference: signed integer value, wrapped to 8 bits.
  function automatic logic [7:0] ref8(input logic [7:0] x);
    int v;
    v = int'(x[6:0]);
    if (x[7]) v = -v;
    return v[7:0];
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
    n_tests++; if (a_ovld !== 1'b0) begin n_fail++; $display("FAIL reset_main_ovld: got %b want 0", a_ovld); end
    n_tests++; if (a_odat !== 8'h00) begin n_fail++; $display("FAIL reset_main_odat: got %h want 00", a_odat); end
    n_tests++; if (a_irdy !== 1'b1) begin n_fail++; $display("FAIL reset_main_irdy: got %b want 1", a_irdy); end
    n_tests++; if (n_ovld !== 1'b0 || n_odat !== 4'h0 || n_irdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_narrow: got vld=%b dat=%h rdy=%b want 0/0/1", n_ovld, n_odat, n_irdy);
    end
    n_tests++; if (w_ovld !== 1'b0 || w_odat !== 8'h00 || w_irdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_wide: got vld=%b dat=%h rdy=%b want 0/00/1", w_ovld, w_odat, w_irdy);
    end
`ifdef ZION_SM2TC_OVF_FLAG_EN
    n_tests++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", a_ovf); end
`endif
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [7:0] vin  [5] = '{8'h85, 8'h7F, 8'h80, 8'hFF, 8'h01};
    logic [7:0] vexp [5] = '{8'hFB, 8'h7F, 8'h00, 8'h81, 8'h01};
    for (int j = 0; j < 8; j++) begin
      step();
      a_ordy = 1'b1;
      if (j < 5) begin a_ivld = 1'b1; a_idat = vin[j]; end
      else       begin a_ivld = 1'b0; a_idat = 8'h00;  end
      settle();
      if (j < 5) begin
        n_tests++; if (a_irdy !== 1'b1) begin n_fail++; $display("FAIL b2b_irdy[%0d]: got %b want 1", j, a_irdy); end
      end
      if (j >= 2 && j <= 6) begin
        n_tests++; if (a_ovld !== 1'b1 || a_odat !== vexp[j-2]) begin
          n_fail++; $display("FAIL b2b_out[%0d]: got vld=%b dat=%h want 1/%h", j, a_ovld, a_odat, vexp[j-2]);
        end
      end else begin
        n_tests++; if (a_ovld !== 1'b0) begin n_fail++; $display("FAIL b2b_idle[%0d]: got vld=%b want 0", j, a_ovld); end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    logic [7:0] vexp [6] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA};
    logic [7:0] got [$];
    int k = 0;
    for (int j = 0; j < 30 && got.size() < 6; j++) begin
      step();
      a_ordy = (j >= 5);
      a_ivld = (k < 6);
      a_idat = 8'h81 + k[7:0];
      settle();
      if (j >= 2 && j <= 4) begin
        n_tests++; if (a_irdy !== 1'b0 || k != 2) begin
          n_fail++; $display("FAIL bp_full[%0d]: got irdy=%b accepted=%0d want 0/2", j, a_irdy, k);
        end
        n_tests++; if (a_ovld !== 1'b1 || a_odat !== 8'hFF) begin
          n_fail++; $display("FAIL bp_hold[%0d]: got vld=%b dat=%h want 1/ff", j, a_ovld, a_odat);
        end
      end
      if (a_ovld && a_ordy) got.push_back(a_odat);
      if (a_ivld && a_irdy) k++;
    end
    a_ivld = 1'b0;
    n_tests++; if (got.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d words want 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_tests++; if (got[i] !== vexp[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], vexp[i]); end
    end
    step();
    settle();
    n_tests++; if (a_ovld !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got vld=%b want 0", a_ovld); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_narrow();
    logic [7:0] vin  [4] = '{8'h88, 8'h89, 8'h08, 8'h07};
    logic [3:0] vexp [4] = '{4'h8, 4'h7, 4'h8, 4'h7};
`ifdef ZION_SM2TC_OVF_FLAG_EN
    logic       vovf [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
`endif
    for (int j = 0; j < 7; j++) begin
      step();
      n_ordy = 1'b1;
      if (j < 4) begin n_ivld = 1'b1; n_idat = vin[j]; end
      else       begin n_ivld = 1'b0; n_idat = 8'h00;  end
      settle();
      if (j >= 2 && j <= 5) begin
        n_tests++; if (n_ovld !== 1'b1 || n_odat !== vexp[j-2]) begin
          n_fail++; $display("FAIL narrow_out[%0d]: got vld=%b dat=%h want 1/%h", j, n_ovld, n_odat, vexp[j-2]);
        end
`ifdef ZION_SM2TC_OVF_FLAG_EN
        n_tests++; if (n_ovf !== vovf[j-2]) begin
          n_fail++; $display("FAIL narrow_ovf[%0d]: got %b want %b", j, n_ovf, vovf[j-2]);
        end
`endif
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wide();
    logic [3:0] vin  [3] = '{4'hF, 4'h7, 4'h8};
    logic [7:0] vexp [3] = '{8'hF9, 8'h07, 8'h00};
    for (int j = 0; j < 6; j++) begin
      step();
      w_ordy = 1'b1;
      if (j < 3) begin w_ivld = 1'b1; w_idat = vin[j]; end
      else       begin w_ivld = 1'b0; w_idat = 4'h0;   end
      settle();
      if (j >= 2 && j <= 4) begin
        n_tests++; if (w_ovld !== 1'b1 || w_odat !== vexp[j-2]) begin
          n_fail++; $display("FAIL wide_out[%0d]: got vld=%b dat=%h want 1/%h", j, w_ovld, w_odat, vexp[j-2]);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random_stall();
    localparam int N = 10000;
    logic [7:0] sb [$];
    logic [7:0] exp_v;
    logic [7:0] hold_dat = 8'h00;
    logic       hold = 1'b0;
    logic       keep = 1'b0;
    int sent = 0, recv = 0, cyc = 0;
    while (recv < N && cyc < 60000) begin
      step();
      cyc++;
      if (!keep) begin
        if (sent < N) begin
          a_ivld = ($urandom_range(3) != 0);
          a_idat = 8'($urandom);
        end else begin
          a_ivld = 1'b0;
        end
      end
      a_ordy = ($urandom_range(3) != 0);
      settle();
      if (a_ovld) begin
        if (hold) begin
          n_tests++; if (a_odat !== hold_dat) begin n_fail++; $display("FAIL rnd_stable: got %h want %h", a_odat, hold_dat); end
        end
        if (a_ordy) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++; $display("FAIL rnd_extra: got %h want no word", a_odat);
          end else begin
            exp_v = sb.pop_front();
            if (a_odat !== exp_v) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", recv, a_odat, exp_v); end
          end
          recv++;
        end
      end
      hold     = a_ovld && !a_ordy;
      hold_dat = a_odat;
      keep     = a_ivld && !a_irdy;
      if (a_ivld && a_irdy) begin sb.push_back(ref8(a_idat)); sent++; end
    end
    n_tests++; if (recv != N) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", recv, N); end
    step();
    a_ivld = 1'b0;
    a_ordy = 1'b1;
    repeat (3) step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    for (int j = 0; j < 3; j++) begin
      step();
      a_ordy = 1'b0;
      a_ivld = 1'b1;
      a_idat = 8'h83 + 8'(j);
      settle();
      if (j == 2) begin
        n_tests++; if (a_irdy !== 1'b0 || a_ovld !== 1'b1) begin
          n_fail++; $display("FAIL rm_full: got irdy=%b vld=%b want 0/1", a_irdy, a_ovld);
        end
      end
    end
    step();
    a_ivld = 1'b0;
    rst    = 1'b1;
    step();
    rst = 1'b0;
    settle();
    n_tests++; if (a_ovld !== 1'b0 || a_odat !== 8'h00 || a_irdy !== 1'b1) begin
      n_fail++; $display("FAIL rm_after: got vld=%b dat=%h irdy=%b want 0/00/1", a_ovld, a_odat, a_irdy);
    end
    for (int j = 0; j < 5; j++) begin
      step();
      a_ordy = 1'b1;
      settle();
      n_tests++; if (a_ovld !== 1'b0) begin n_fail++; $display("FAIL rm_leak[%0d]: got vld=%b dat=%h want no word", j, a_ovld, a_odat); end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst    = 1'b1;
    a_ivld = 1'b0; a_idat = 8'h00; a_ordy = 1'b1;
    n_ivld = 1'b0; n_idat = 8'h00; n_ordy = 1'b1;
    w_ivld = 1'b0; w_idat = 4'h0;  w_ordy = 1'b1;

    test_reset();
    test_back_to_back();
    test_backpressure();
    test_narrow();
    test_wide();
    test_random_stall();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zion_sign_mag_to_twos_pipe.md
Name: zion_sign_mag_to_twos_pipe

Overview:
- Streaming converter from sign-magnitude words to two's-complement words; the inverse-direction companion of the library's two's-complement negation primitive.
- Sits between fixed-point datapath blocks that exchange sign-magnitude operands, e.g. after multiplier magnitude paths, before accumulators.
- Two-stage pipeline with valid/ready handshake on both sides, full throughput, lossless backpressure.

Parameters:
- WIDTH_IN, 8, input word width; MSB = sign, [WIDTH_IN-2:0] = magnitude; legal range >= 2.
- WIDTH_OUT, 8, output two's-complement width; legal range >= 2; may differ from WIDTH_IN.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- iVld  input  1  input word valid
- iRdy  output  1  converter can accept a word this cycle
- iDat  input  WIDTH_IN  sign-magnitude input word
- oVld  output  1  output word valid
- oRdy  input  1  downstream accepts the output word
- oDat  output  WIDTH_OUT  two's-complement result

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Transfer occurs on a rising edge where Vld & Rdy are both 1. A producer holding Vld must keep Dat stable until the transfer.
- Arithmetic:
  - mag is iDat[WIDTH_IN-2:0], zero-extended or truncated to WIDTH_OUT bits.
  - sign=0: oDat = mag.
  - sign=1: oDat = ~mag + 1, modulo 2^WIDTH_OUT.
  - Negative zero (sign=1, mag=0) yields 0.
- Stage 1 (S1) registers:
  - s1_sign
  - s1_inv = sign ? ~mag : mag
  - s1_cin = sign
- Stage 2 (S2) registers s1_inv + s1_cin. Its data register drives oDat and its valid bit drives oVld. Nothing is added combinationally after the S2 register.
- Latency: exactly 2 cycles from input transfer to oVld, with no stall.
- Throughput: one word per cycle while oRdy=1.
- Flow control:
  - s2_adv = ~s2_vld | oRdy
  - s1_adv = ~s1_vld | s2_adv
  - iRdy = s1_adv
  - There is a combinational path from oRdy to iRdy; there is no skid buffer.
- Full: when both stages are valid and oRdy=0, iRdy=0 and S1/S2 contents are held unchanged.
- Empty: with no input, oVld falls 1 cycle after the last output transfer.
- Simultaneous accept and emit in the same cycle is legal, with no bubble inserted.
- Output ordering is strictly FIFO; words are never dropped or duplicated.
- Reset:
  - All valid bits and data registers clear to 0, so oVld=0 and oDat=0.
  - iRdy=1 in the first cycle after reset deasserts.
  - Reset mid-stream discards in-flight words with no output.
- iDat is ignored whenever iVld=0 or iRdy=0.

Optional Feature:
- Macro ZION_SM2TC_OVF_FLAG_EN.
- When defined:
  - Extra output port oOvf (output, 1 bit), aligned with oDat and qualified by oVld.
  - oOvf=1 when the input value is not representable in WIDTH_OUT bits: positive mag > 2^(WIDTH_OUT-1)-1, or negative mag > 2^(WIDTH_OUT-1).
  - The flag is computed at full input precision in S1 and pipelined with the data. It resets to 0.
  - oDat still carries the wrapped (truncated) result.
- When not defined: the port and its logic are absent, and the wrapped result is unchanged.

Test Plan:
1. Basic values, WIDTH_IN=WIDTH_OUT=8, oRdy=1: drive 0x85, 0x7F, 0x80, 0xFF, 0x01 back-to-back. Required oDat: 0xFB, 0x7F, 0x00, 0x81, 0x01, on consecutive cycles starting 2 cycles after the first transfer.
2. Backpressure: stream 0x81..0x86 with oRdy=0 for 5 cycles, then 1.
   - iRdy drops after 2 words are accepted.
   - Outputs 0xFF, 0xFE, 0xFD, 0xFC, 0xFB, 0xFA appear in order with no loss or duplication.
   - oDat is stable while oVld=1 and oRdy=0.
3. Random stall: random iVld/oRdy over 10k words. A scoreboard checks every output equals the reference negation model and ordering is preserved.
4. Narrow output, WIDTH_IN=8, WIDTH_OUT=4, macro defined:
   - 0x88 gives oDat=0x8, oOvf=0.
   - 0x89 gives oDat=0x7, oOvf=1.
   - 0x08 gives oDat=0x8, oOvf=1.
   - 0x07 gives oDat=0x7, oOvf=0.
5. Reset mid-operation: fill both stages with oRdy=0, then assert rst for 1 cycle.
   - Next cycle: oVld=0, oDat=0, iRdy=1.
   - No pre-reset word ever appears at the output.
6. Wide output, WIDTH_IN=4, WIDTH_OUT=8: 0xF maps to 0xF9, 0x7 to 0x07, and 0x8 to 0x00.
